// File: rtl/wb_debug_mirror.sv
`default_nettype none
// ============================================================================
// Module      : wb_debug_mirror
// Description : Wishbone write mirror; buffers window writes in a FIFO and
//               replays each one on the GPIO pads as data/address/strobe.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_debug_mirror #(
    parameter logic [31:0] BASE_ADDR   = 32'h3000_0000,
    parameter int          DEPTH       = 4,
    parameter int          HOLD_CYCLES = 8
) (
    input  logic        wb_clk_i,
    input  logic        resetb,
    input  logic        wbs_stb_i,
    input  logic        wbs_cyc_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o,
    output logic [37:0] io_out,
    output logic [37:0] io_oeb
);

    localparam int              c_aw        = $clog2(DEPTH);
    localparam logic [c_aw:0]   c_full_lvl  = (c_aw + 1)'(DEPTH);
    localparam logic [7:0]      c_hold_m1   = 8'(HOLD_CYCLES - 1);
    localparam logic [7:0]      c_clr_off   = 8'hFC;

    localparam logic [1:0]      c_st_idle   = 2'd0;
    localparam logic [1:0]      c_st_strobe = 2'd1;
    localparam logic [1:0]      c_st_gap    = 2'd2;

    logic            r_ack;
    logic [31:0]     r_dat;
    logic [31:0]     r_mem [DEPTH];
    logic [c_aw-1:0] r_wr_ptr;
    logic [c_aw-1:0] r_rd_ptr;
    logic [c_aw:0]   r_count;
    logic [7:0]      r_drop;
    logic [1:0]      r_state;
    logic [7:0]      r_cnt;
    logic [31:0]     r_pad;
    logic            r_strobe;

    logic            w_hit;
    logic            w_accept;
    logic            w_wr;
    logic            w_clr;
    logic            w_wr_data;
    logic            w_empty;
    logic            w_full;
    logic            w_pop;
    logic            w_push;
    logic            w_drop;
    logic [7:0]      w_level;
    logic            w_unused_ok;

    assign w_hit     = wbs_stb_i & wbs_cyc_i & (wbs_adr_i[31:8] == BASE_ADDR[31:8]);
    assign w_accept  = w_hit & ~r_ack;
    assign w_wr      = w_accept & wbs_we_i;
    assign w_clr     = w_wr & (wbs_adr_i[7:0] == c_clr_off);
    assign w_wr_data = w_wr & ~w_clr;
    assign w_empty   = (r_count == '0);
    assign w_full    = (r_count == c_full_lvl);
    assign w_pop     = (r_state == c_st_idle) & ~w_empty;
    // A pop in the same cycle frees the slot, so a full FIFO can still accept.
    assign w_push    = w_wr_data & (~w_full | w_pop);
    assign w_drop    = w_wr_data & w_full & ~w_pop;
    assign w_level   = 8'(r_count);

    assign w_unused_ok = ^{wbs_sel_i, wbs_dat_i[31:16]};

    always_ff @(posedge wb_clk_i) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {wbs_adr_i[15:0], wbs_dat_i[15:0]};
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (!resetb) begin
            r_ack    <= 1'b0;
            r_dat    <= 32'h0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_drop   <= 8'h0;
            r_state  <= c_st_idle;
            r_cnt    <= 8'h0;
            r_pad    <= 32'h0;
            r_strobe <= 1'b0;
        end else begin
            r_ack <= w_accept;
            r_dat <= w_accept ? {r_drop, 16'h0, w_level} : 32'h0;

            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase

            if (w_clr) begin
                r_drop <= 8'h0;
            end else if (w_drop && (r_drop != 8'hFF)) begin
                r_drop <= r_drop + 8'h1;
            end

            case (r_state)
                c_st_idle: begin
                    if (w_pop) begin
                        r_pad    <= r_mem[r_rd_ptr];
                        r_strobe <= 1'b1;
                        r_cnt    <= c_hold_m1;
                        r_state  <= c_st_strobe;
                    end
                end
                c_st_strobe: begin
                    if (r_cnt == 8'h0) begin
                        r_strobe <= 1'b0;
                        r_cnt    <= c_hold_m1;
                        r_state  <= c_st_gap;
                    end else begin
                        r_cnt <= r_cnt - 8'h1;
                    end
                end
                c_st_gap: begin
                    if (r_cnt == 8'h0) begin
                        r_state <= c_st_idle;
                    end else begin
                        r_cnt <= r_cnt - 8'h1;
                    end
                end
                default: begin
                    r_strobe <= 1'b0;
                    r_state  <= c_st_idle;
                end
            endcase
        end
    end

    assign wbs_ack_o = r_ack;
    assign wbs_dat_o = r_dat;
    assign io_out    = {5'b0, r_strobe, r_pad};
    assign io_oeb    = {5'b11111, 33'b0};

endmodule
`default_nettype wire

// File: tb/tb_wb_debug_mirror.sv
`default_nettype none
// ============================================================================
// Module      : tb_wb_debug_mirror
// Description : Self-checking bench for wb_debug_mirror (vector table plus
//               pad-replay scoreboard).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wb_debug_mirror;

    localparam int HOLD = 8;

    logic        wb_clk_i = 1'b0;
    logic        resetb   = 1'b0;
    logic        wbs_stb_i = 1'b0;
    logic        wbs_cyc_i = 1'b0;
    logic        wbs_we_i  = 1'b0;
    logic [3:0]  wbs_sel_i = 4'hF;
    logic [31:0] wbs_adr_i = 32'h0;
    logic [31:0] wbs_dat_i = 32'h0;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;
    logic [37:0] io_out;
    logic [37:0] io_oeb;

    wb_debug_mirror #(
        .BASE_ADDR  (32'h3000_0000),
        .DEPTH      (4),
        .HOLD_CYCLES(HOLD)
    ) dut (
        .wb_clk_i (wb_clk_i),
        .resetb   (resetb),
        .wbs_stb_i(wbs_stb_i),
        .wbs_cyc_i(wbs_cyc_i),
        .wbs_we_i (wbs_we_i),
        .wbs_sel_i(wbs_sel_i),
        .wbs_adr_i(wbs_adr_i),
        .wbs_dat_i(wbs_dat_i),
        .wbs_ack_o(wbs_ack_o),
        .wbs_dat_o(wbs_dat_o),
        .io_out   (io_out),
        .io_oeb   (io_oeb)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    typedef struct {
        logic [31:0] adr;
        logic [31:0] dat;
        logic        we;
        logic        exp_ack;
        logic        exp_push;
        logic [31:0] exp_rd;
        int          idle;
    } vec_t;

    vec_t        vecs [7];
    logic [31:0] exp_q [$];
    int          rise_q [$];
    int          n_chk = 0;
    int          n_err = 0;
    int          cyc_n = 0;
    int          hi_n  = 0;
    logic        prev_stb = 1'b0;
    bit          mon_en = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge wb_clk_i);
        #1;
    endtask

    task automatic wb_xfer(input logic [31:0] adr, input logic [31:0] dat, input logic we,
                           output logic acked, output logic [31:0] rdat, output int lat);
        wbs_adr_i = adr;
        wbs_dat_i = dat;
        wbs_we_i  = we;
        wbs_stb_i = 1'b1;
        wbs_cyc_i = 1'b1;
        acked = 1'b0;
        rdat  = 32'h0;
        lat   = 0;
        for (int i = 1; i <= 4 && !acked; i++) begin
            @(posedge wb_clk_i);
            #1;
            if (wbs_ack_o) begin
                acked = 1'b1;
                lat   = i;
                rdat  = wbs_dat_o;
            end
        end
        wbs_stb_i = 1'b0;
        wbs_cyc_i = 1'b0;
        wbs_we_i  = 1'b0;
    endtask

    // Pad monitor: each strobe rise pops the scoreboard, each fall checks width.
    always @(posedge wb_clk_i) begin
        #2;
        cyc_n++;
        if (!mon_en) begin
            prev_stb = 1'b0;
            hi_n     = 0;
        end else begin
            if (io_out[32]) begin
                if (!prev_stb) begin
                    rise_q.push_back(cyc_n);
                    if (exp_q.size() == 0) begin
                        n_chk++;
                        n_err++;
                        $display("FAIL unexpected_strobe: got pads %h expected no replay", io_out[31:0]);
                    end else begin
                        chk("replay_pads", io_out[31:0], exp_q.pop_front());
                    end
                end
                hi_n++;
            end else if (prev_stb) begin
                chk("strobe_width", hi_n, HOLD);
                hi_n = 0;
            end
            prev_stb = io_out[32];
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        acked;
        logic [31:0] rd;
        int          lat;
        bit          seen;

        vecs[0] = '{32'h3000_0010, 32'hDEAD_BEEF, 1'b1, 1'b1, 1'b1, 32'h0, 40};
        vecs[1] = '{32'h3000_0100, 32'h0000_1234, 1'b1, 1'b0, 1'b0, 32'h0, 2};
        vecs[2] = '{32'h2000_0000, 32'h0000_5678, 1'b1, 1'b0, 1'b0, 32'h0, 2};
        vecs[3] = '{32'h3000_0000, 32'h0,         1'b0, 1'b1, 1'b0, 32'h0, 2};
        vecs[4] = '{32'h3000_00FC, 32'h1234_5678, 1'b1, 1'b1, 1'b0, 32'h0, 2};
        vecs[5] = '{32'h3000_0080, 32'h0,         1'b0, 1'b1, 1'b0, 32'h0, 2};
        vecs[6] = '{32'h3000_00F8, 32'hCAFE_0001, 1'b1, 1'b1, 1'b1, 32'h0, 40};

        // Reset held with a live hit request
        resetb    = 1'b0;
        wbs_stb_i = 1'b1;
        wbs_cyc_i = 1'b1;
        wbs_we_i  = 1'b1;
        wbs_adr_i = 32'h3000_0010;
        wbs_dat_i = 32'h1;
        repeat (5) begin
            @(posedge wb_clk_i);
            #1;
            chk("reset_ack", wbs_ack_o, 0);
        end
        chk("reset_io_out", io_out, 0);
        chk("reset_io_oeb", io_oeb, 38'h3E_0000_0000);
        wbs_stb_i = 1'b0;
        wbs_cyc_i = 1'b0;
        wbs_we_i  = 1'b0;
        resetb    = 1'b1;
        mon_en    = 1'b1;
        idle(2);

        for (int i = 0; i < 7; i++) begin
            if (vecs[i].exp_push) exp_q.push_back({vecs[i].adr[15:0], vecs[i].dat[15:0]});
            wb_xfer(vecs[i].adr, vecs[i].dat, vecs[i].we, acked, rd, lat);
            chk($sformatf("vec%0d_ack", i), acked, vecs[i].exp_ack);
            if (vecs[i].exp_ack) begin
                chk($sformatf("vec%0d_latency", i), lat, 1);
                if (!vecs[i].we) chk($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rd);
            end
            @(posedge wb_clk_i);
            #1;
            chk($sformatf("vec%0d_ack_low", i), wbs_ack_o, 0);
            chk($sformatf("vec%0d_dat_low", i), wbs_dat_o, 0);
            idle(vecs[i].idle);
        end

        // Overflow: six back-to-back writes while the first replays
        for (int i = 0; i < 6; i++) begin
            if (i < 5) exp_q.push_back({16'h0020 + 16'(4 * i), 16'hA000 + 16'(i)});
            wb_xfer(32'h3000_0020 + 32'(4 * i), 32'h0000_A000 + 32'(i), 1'b1, acked, rd, lat);
            chk($sformatf("ovf_ack%0d", i), acked, 1);
        end
        wb_xfer(32'h3000_0000, 32'h0, 1'b0, acked, rd, lat);
        chk("ovf_status", rd, 32'h0100_0004);
        wb_xfer(32'h3000_00FC, 32'h0, 1'b1, acked, rd, lat);
        chk("ovf_clear_ack", acked, 1);
        wb_xfer(32'h3000_0004, 32'h0, 1'b0, acked, rd, lat);
        chk("ovf_status_cleared", rd, 32'h0000_0004);
        idle(120);
        chk("ovf_drained", exp_q.size(), 0);

        // Ordering and pop-to-pop spacing
        rise_q.delete();
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back({16'h0030 + 16'(4 * i), 16'h1111 * 16'(i + 1)});
            wb_xfer(32'h3000_0030 + 32'(4 * i), 32'h1111 * 32'(i + 1), 1'b1, acked, rd, lat);
        end
        idle(80);
        chk("order_rise_count", rise_q.size(), 3);
        if (rise_q.size() >= 3) begin
            chk("order_spacing1", rise_q[1] - rise_q[0], 2 * HOLD + 1);
            chk("order_spacing2", rise_q[2] - rise_q[1], 2 * HOLD + 1);
        end

        // Reset during STROBE with one entry still buffered
        exp_q.push_back(32'h0040_AAAA);
        wb_xfer(32'h3000_0040, 32'h5555_AAAA, 1'b1, acked, rd, lat);
        exp_q.push_back(32'h0044_6666);
        wb_xfer(32'h3000_0044, 32'h0000_6666, 1'b1, acked, rd, lat);
        seen = 1'b0;
        for (int k = 0; k < 10 && !seen; k++) begin
            @(posedge wb_clk_i);
            #1;
            seen = io_out[32];
        end
        chk("mid_strobe_seen", seen, 1);
        idle(2);
        mon_en = 1'b0;
        resetb = 1'b0;
        @(posedge wb_clk_i);
        #1;
        chk("mid_reset_io_out", io_out, 0);
        resetb = 1'b1;
        exp_q.delete();
        idle(1);
        mon_en = 1'b1;
        chk("post_reset_io_out", io_out, 0);
        wb_xfer(32'h3000_0000, 32'h0, 1'b0, acked, rd, lat);
        chk("post_reset_status", rd, 32'h0);
        exp_q.push_back(32'h0048_7777);
        wb_xfer(32'h3000_0048, 32'h0000_7777, 1'b1, acked, rd, lat);
        chk("restart_ack", acked, 1);
        idle(40);
        chk("restart_drained", exp_q.size(), 0);
        chk("final_io_hi", io_out[37:33], 0);
        chk("final_io_oeb", io_oeb, 38'h3E_0000_0000);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
